// File: rtl/div_ctrl.sv
// Moore controller for the 4-bit restoring divider: sequences load, shift/subtract
// iterations and the final remainder fix-up, with a four-phase go/done handshake.
module div_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic error,
    input  logic r_lt_y,
    input  logic cnt_out,
    output logic ld_r,
    output logic ld_x,
    output logic ld_y,
    output logic sl,
    output logic sr,
    output logic right_in_x,
    output logic sel1,
    output logic sel2,
    output logic ld_cnt,
    output logic ce,
    output logic ud,
    output logic busy,
    output logic done,
    output logic div_err
);

    typedef enum logic [3:0] {
        IDLE, LOAD, SHL0, TEST, SUB, SHL, CHK, FIX, DONE, ERR
    } state_t;

    state_t state, state_n;
    logic   q_bit, q_n;

    always_comb begin
        state_n = state;
        q_n     = q_bit;
        case (state)
            IDLE: if (go) state_n = error ? ERR : LOAD;
            LOAD: state_n = SHL0;
            SHL0: state_n = TEST;
            TEST: begin
                if (r_lt_y) begin
                    state_n = SHL;
                    q_n     = 1'b0;
                end else begin
                    state_n = SUB;
                end
            end
            SUB: begin
                state_n = SHL;
                q_n     = 1'b1;
            end
            SHL:  state_n = CHK;
            CHK:  state_n = cnt_out ? FIX : TEST;
            FIX:  state_n = DONE;
            DONE: if (!go) state_n = IDLE;
            ERR:  if (!go) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet still
    // line up cycle-for-cycle with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            q_bit      <= 1'b0;
            ld_r       <= 1'b0;
            ld_x       <= 1'b0;
            ld_y       <= 1'b0;
            sl         <= 1'b0;
            sr         <= 1'b0;
            right_in_x <= 1'b0;
            sel1       <= 1'b0;
            sel2       <= 1'b1;
            ld_cnt     <= 1'b0;
            ce         <= 1'b0;
            ud         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            state      <= state_n;
            q_bit      <= q_n;
            ld_r       <= 1'b0;
            ld_x       <= 1'b0;
            ld_y       <= 1'b0;
            sl         <= 1'b0;
            sr         <= 1'b0;
            right_in_x <= 1'b0;
            sel1       <= 1'b0;
            sel2       <= 1'b1;
            ld_cnt     <= 1'b0;
            ce         <= 1'b0;
            ud         <= 1'b0;
            busy       <= !(state_n inside {IDLE, DONE, ERR});
            done       <= 1'b0;
            div_err    <= 1'b0;
            case (state_n)
                LOAD: begin
                    ld_x   <= 1'b1;
                    ld_y   <= 1'b1;
                    ld_r   <= 1'b1;
                    sel1   <= 1'b1;
                    ld_cnt <= 1'b1;
                end
                SHL0: sl <= 1'b1;
                SUB:  ld_r <= 1'b1;
                SHL: begin
                    sl         <= 1'b1;
                    ce         <= 1'b1;
                    right_in_x <= q_n;
                end
                FIX:  sr <= 1'b1;
                DONE: begin
                    done <= 1'b1;
                    sel2 <= 1'b0;
                end
                ERR: begin
                    done    <= 1'b1;
                    div_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a stubbed iteration counter and comparator input.
module tb_div_ctrl;

    logic clk = 1'b0;
    logic rst, go, error, r_lt_y, cnt_out;
    logic ld_r, ld_x, ld_y, sl, sr, right_in_x, sel1, sel2;
    logic ld_cnt, ce, ud, busy, done, div_err;
    logic [2:0] cnt = 3'd0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_ctrl dut (
        .clk(clk), .rst(rst), .go(go), .error(error), .r_lt_y(r_lt_y),
        .cnt_out(cnt_out), .ld_r(ld_r), .ld_x(ld_x), .ld_y(ld_y), .sl(sl),
        .sr(sr), .right_in_x(right_in_x), .sel1(sel1), .sel2(sel2),
        .ld_cnt(ld_cnt), .ce(ce), .ud(ud), .busy(busy), .done(done),
        .div_err(div_err)
    );

    // Datapath counter stub: load 4, count on ce, terminal flag at zero.
    always @(posedge clk) begin
        if (ld_cnt) cnt <= 3'd4;
        else if (ce) cnt <= ud ? cnt + 3'd1 : cnt - 3'd1;
    end
    assign cnt_out = (cnt == 3'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one division from IDLE with go already high; gathers observations.
    task automatic run_div(input logic lt, output int done_cyc, output int ce_n,
                           output int ldc_n, output int sr_cyc, output int rix1,
                           output int subld, output int sl_n, output int busy_gaps);
        r_lt_y = lt;
        done_cyc = -1; ce_n = 0; ldc_n = 0; sr_cyc = -1;
        rix1 = 0; subld = 0; sl_n = 0; busy_gaps = 0;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            step();
            if (done) done_cyc = c;
            else if (!busy) busy_gaps++;
            if (ce) ce_n++;
            if (ld_cnt) ldc_n++;
            if (sr) sr_cyc = c;
            if (sl && ce && right_in_x) rix1++;
            if (ld_r && !sel1) subld++;
            if (sl) sl_n++;
        end
    endtask

    task automatic test_reset();
        logic [13:0] outs;
        rst = 1'b1; go = 1'b1; error = 1'b0; r_lt_y = 1'b1;
        step();
        step();
        outs = {ld_r, ld_x, ld_y, sl, sr, right_in_x, sel1, sel2,
                ld_cnt, ce, ud, busy, done, div_err};
        checks++;
        if (outs !== 14'b00000001000000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", outs, 14'b00000001000000);
        end
        rst = 1'b0;
        step();
        checks++;
        if (ld_x !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_load: ld_x=%b busy=%b expected 1 1", ld_x, busy);
        end
        for (int c = 0; c < 40 && done !== 1'b1; c++) step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_done: done=%b expected 1", done);
        end
        go = 1'b0;
        step();
    endtask

    task automatic test_no_sub();
        int dc, cen, ldc, src, rix, sub, sln, bg;
        go = 1'b1;
        run_div(1'b1, dc, cen, ldc, src, rix, sub, sln, bg);
        checks++;
        if (dc !== 16) begin errors++; $display("FAIL nosub_done_cycle: got %0d expected 16", dc); end
        checks++;
        if (cen !== 4 || ldc !== 1) begin
            errors++; $display("FAIL nosub_counter: ce=%0d ld_cnt=%0d expected 4 1", cen, ldc);
        end
        checks++;
        if (src !== 15 || sln !== 5) begin
            errors++; $display("FAIL nosub_shifts: sr_cycle=%0d sl=%0d expected 15 5", src, sln);
        end
        checks++;
        if (rix !== 0 || sub !== 0 || bg !== 0) begin
            errors++; $display("FAIL nosub_qbits: q1=%0d sub=%0d busy_gaps=%0d expected 0 0 0", rix, sub, bg);
        end
        checks++;
        if (sel2 !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL nosub_done_outputs: sel2=%b busy=%b expected 0 0", sel2, busy);
        end
        go = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || sel2 !== 1'b1) begin
            errors++; $display("FAIL nosub_release: done=%b sel2=%b expected 0 1", done, sel2);
        end
    endtask

    task automatic test_all_sub();
        int dc, cen, ldc, src, rix, sub, sln, bg;
        go = 1'b1;
        run_div(1'b0, dc, cen, ldc, src, rix, sub, sln, bg);
        checks++;
        if (dc !== 20) begin errors++; $display("FAIL sub_done_cycle: got %0d expected 20", dc); end
        checks++;
        if (sub !== 4 || rix !== 4) begin
            errors++; $display("FAIL sub_pulses: sub_ld_r=%0d q1=%0d expected 4 4", sub, rix);
        end
        checks++;
        if (cen !== 4 || src !== 19) begin
            errors++; $display("FAIL sub_counts: ce=%0d sr_cycle=%0d expected 4 19", cen, src);
        end
        go = 1'b0;
        step();
    endtask

    task automatic test_error();
        go = 1'b1; error = 1'b1;
        step();
        checks++;
        if ({done, div_err, sel2, busy, ld_r, ld_x, ld_y} !== 7'b1110000) begin
            errors++;
            $display("FAIL err_enter: got %b expected 1110000",
                     {done, div_err, sel2, busy, ld_r, ld_x, ld_y});
        end
        error = 1'b0;
        step();
        checks++;
        if (done !== 1'b1 || div_err !== 1'b1) begin
            errors++; $display("FAIL err_hold: done=%b div_err=%b expected 1 1", done, div_err);
        end
        go = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || div_err !== 1'b0 || sel2 !== 1'b1) begin
            errors++; $display("FAIL err_release: done=%b div_err=%b sel2=%b expected 0 0 1", done, div_err, sel2);
        end
    endtask

    task automatic test_reset_mid();
        int dc, cen, ldc, src, rix, sub, sln, bg;
        logic [13:0] outs;
        go = 1'b1; r_lt_y = 1'b0;
        for (int c = 1; c <= 8; c++) step();
        checks++;
        if (ld_r !== 1'b1 || sel1 !== 1'b0) begin
            errors++; $display("FAIL mid_second_sub: ld_r=%b sel1=%b expected 1 0", ld_r, sel1);
        end
        rst = 1'b1; go = 1'b0;
        step();
        outs = {ld_r, ld_x, ld_y, sl, sr, right_in_x, sel1, sel2,
                ld_cnt, ce, ud, busy, done, div_err};
        checks++;
        if (outs !== 14'b00000001000000) begin
            errors++; $display("FAIL mid_reset_outputs: got %b expected %b", outs, 14'b00000001000000);
        end
        rst = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0 || ld_x !== 1'b0) begin
            errors++; $display("FAIL mid_idle_hold: busy=%b ld_x=%b expected 0 0", busy, ld_x);
        end
        go = 1'b1;
        run_div(1'b0, dc, cen, ldc, src, rix, sub, sln, bg);
        checks++;
        if (dc !== 20 || cen !== 4 || rix !== 4) begin
            errors++; $display("FAIL mid_restart: done_cycle=%0d ce=%0d q1=%0d expected 20 4 4", dc, cen, rix);
        end
        go = 1'b0;
        step();
    endtask

    task automatic test_done_hold();
        int dc, cen, ldc, src, rix, sub, sln, bg;
        go = 1'b1;
        run_div(1'b1, dc, cen, ldc, src, rix, sub, sln, bg);
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (done !== 1'b1 || sel2 !== 1'b0) begin
                errors++; $display("FAIL hold_done_%0d: done=%b sel2=%b expected 1 0", c, done, sel2);
            end
        end
        go = 1'b0;
        step();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL hold_release: done=%b expected 0", done); end
        go = 1'b1;
        step();
        checks++;
        if (ld_x !== 1'b1 || ld_cnt !== 1'b1) begin
            errors++; $display("FAIL hold_restart: ld_x=%b ld_cnt=%b expected 1 1", ld_x, ld_cnt);
        end
        for (int c = 0; c < 40 && done !== 1'b1; c++) step();
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL hold_second_done: done=%b expected 1", done); end
        go = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_no_sub();
        test_all_sub();
        test_error();
        test_reset_mid();
        test_done_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Moore-style controller that sequences the 4-bit restoring-division datapath (R/X/Y shift registers, subtractor, comparator, iteration counter) through load, shift/subtract iterations and remainder correction. It accepts a start request and reports completion or divide-by-zero through a four-phase go/done handshake. It sits between the top-level divider wrapper and the datapath, and owns every datapath control line.

## Interface
- No parameters. Quotient width is fixed at 4 and the iteration count is fixed at 4. The counter load value is supplied by the datapath.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- go  in  1  start request (level); must be held until done rises
- error  in  1  divisor-is-zero flag from datapath
- r_lt_y  in  1  R[3:0] < Y comparison from datapath
- cnt_out  in  1  iteration counter terminal flag (1 when count == 0)
- ld_r, ld_x, ld_y  out  1 each  parallel-load enables for R, X, Y
- sl, sr  out  1 each  shift-left / shift-right enables
- right_in_x  out  1  quotient bit shifted into X LSB
- sel1  out  1  R load source: 0 = subtractor, 1 = zero
- sel2  out  1  result gate: 0 = drive quotient/remainder, 1 = force zero
- ld_cnt, ce, ud  out  1 each  counter load, count enable, direction (0 = down)
- busy  out  1  1 in every state except IDLE, DONE and ERR
- done  out  1  result (or error) valid
- div_err  out  1  divide-by-zero reported

## Operation
- States: IDLE, LOAD, SHL0, TEST, SUB, SHL, CHK, FIX, DONE, ERR.
- All outputs are decoded from the state register only (Moore). Unlisted outputs are 0 in each state.
- **IDLE**: sel2=1.
  - go=1, error=0 -> LOAD.
  - go=1, error=1 -> ERR.
  - Otherwise stay in IDLE.
- **LOAD**: ld_x=1, ld_y=1, ld_r=1, sel1=1 (R=0), ld_cnt=1, sel2=1. -> SHL0.
- **SHL0**: sl=1, right_in_x=0, sel2=1. Initial shift of R:X. -> TEST.
- **TEST**: sel2=1.
  - r_lt_y=0 -> SUB.
  - r_lt_y=1 -> SHL with q-bit 0.
- **SUB**: ld_r=1, sel1=0, sel2=1 (R = R - Y). -> SHL with q-bit 1.
- **SHL**: sl=1, ce=1, ud=0, sel2=1. right_in_x = q-bit, held in a 1-bit register set on entry. -> CHK.
- **CHK**: sel2=1.
  - cnt_out=1 -> FIX.
  - Otherwise -> TEST.
- **FIX**: sr=1, sel2=1. Undoes the surplus left shift of R. -> DONE.
- **DONE**: done=1, sel2=0.
  - Stay while go=1.
  - go=0 -> IDLE.
- **ERR**: done=1, div_err=1, sel2=1.
  - Stay while go=1.
  - go=0 -> IDLE.
- Changes to error or go after leaving IDLE are ignored until DONE/ERR.
- rst=1 at any edge, including mid-iteration: state goes to IDLE and the q-bit register clears. Datapath registers are not touched by the controller during reset.

## Timing
- Reset values: sel2=1. All other outputs are 0 (ld_*, sl, sr, right_in_x, sel1, ld_cnt, ce, ud, busy, done, div_err).
- Edge 0 is the edge that samples go=1 in IDLE. LOAD occupies cycle 1 and SHL0 cycle 2.
- Each iteration takes 3 cycles (TEST, SHL, CHK), or 4 cycles when SUB is taken.
- FIX occupies cycle 15+k, where k is the number of 1 quotient bits. done first rises in cycle 16+k, giving 16..20 cycles of latency.
- Error path: ERR is entered in cycle 1 and done/div_err rise in cycle 1.
- done falls one cycle after go is sampled 0. A new go is accepted no earlier than the cycle after IDLE is re-entered.
- ce pulses exactly once per iteration, 4 pulses per division. ld_cnt pulses once. sr pulses once.

## Test plan
- Reset: hold rst=1 for 2 cycles with go=1 -> sel2=1, all other outputs 0, busy=0. The state stays IDLE for one further cycle after rst falls only if go=0.
- Stubbed datapath with r_lt_y=1 always and a counter model (load 4, decrement on ce) -> sequence LOAD, SHL0, 4×(TEST, SHL, CHK), FIX, DONE. right_in_x=0 on every SHL. done at cycle 16.
- r_lt_y=0 on every TEST -> SUB precedes each SHL, right_in_x=1 on all 4 SHL cycles, done at cycle 20, exactly 4 ld_r pulses with sel1=0.
- go=1 with error=1 -> ERR in cycle 1 with done=1, div_err=1, sel2=1, no ld_* pulses. Drop go -> IDLE next cycle.
- Assert rst during the second SUB -> IDLE after that edge with reset output values. A fresh go then restarts at LOAD with a full 4-iteration sequence.
- Hold go=1 for 5 cycles in DONE -> done and sel2=0 held throughout. Drop go -> done=0 next cycle. Re-assert go on the following cycle -> LOAD.
